// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_scan_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  localparam int DEF_DIGIT_CYC = 100000;
  localparam int DEF_BLANK_CYC = 1000;

  // Ceiling log2, never below 1 so a 2-digit index still gets a bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 << i) < n) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Per-slot cycle counter; flags the end of the blanking gap and of the slot.
module scan_prescaler
  import seg_scan_pkg::*;
#(
  parameter int DIGIT_CYC = DEF_DIGIT_CYC,
  parameter int BLANK_CYC = DEF_BLANK_CYC,
  parameter int CNT_W     = 17
) (
  input  logic clk,
  input  logic rst_n,
  output logic blank_end,
  output logic slot_end
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    blank_end = (cnt_q == CNT_W'(BLANK_CYC - 1));
    slot_end  = (cnt_q == CNT_W'(DIGIT_CYC - 1));
    if (slot_end) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed common-anode display scanner with frame-synchronous updates.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_CYC  = DEF_DIGIT_CYC,
  parameter int BLANK_CYC  = DEF_BLANK_CYC,
  parameter int CNT_W      = 17
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    dp_n,
  output logic                    frame_done,
  output logic                    pending
);

  localparam int VAL_W = 4 * NUM_DIGITS;
  localparam int IDX_W = clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{1'b1}};

  logic blank_end;
  logic slot_end;

  scan_state_e           state_q;
  logic [IDX_W-1:0]      idx_q;
  logic [IDX_W-1:0]      idx_nxt;
  logic [VAL_W-1:0]      shadow_q;
  logic [NUM_DIGITS-1:0] shadow_dp_q;
  logic [VAL_W-1:0]      act_q;
  logic [VAL_W-1:0]      act_d;
  logic [NUM_DIGITS-1:0] act_dp_q;
  logic [NUM_DIGITS-1:0] act_dp_d;
  logic                  pending_q;
  logic                  frame_end;
  logic                  act_upd;
  logic [NUM_DIGITS-1:0] an_drive;
  logic [3:0]            bcd_q;
  logic [NUM_DIGITS-1:0] an_n_q;
  logic                  dp_n_q;
  logic                  frame_done_q;

  scan_prescaler #(
    .DIGIT_CYC (DIGIT_CYC),
    .BLANK_CYC (BLANK_CYC),
    .CNT_W     (CNT_W)
  ) u_prescaler (
    .clk       (clk),
    .rst_n     (rst_n),
    .blank_end (blank_end),
    .slot_end  (slot_end)
  );

  // A load on the boundary cycle wins over a pending shadow frame.
  always_comb begin
    frame_end = slot_end && (state_q == ST_DRIVE) && (idx_q == LAST_IDX);
    act_upd   = frame_end && (load || pending_q);
    if (idx_q == LAST_IDX) begin
      idx_nxt = {IDX_W{1'b0}};
    end else begin
      idx_nxt = idx_q + IDX_W'(1);
    end
    if (frame_end && load) begin
      act_d    = value;
      act_dp_d = dp_in;
    end else if (frame_end && pending_q) begin
      act_d    = shadow_q;
      act_dp_d = shadow_dp_q;
    end else begin
      act_d    = act_q;
      act_dp_d = act_dp_q;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] supp_q;
  logic [NUM_DIGITS-1:0] supp_mask;
  logic                  zero_run;

  // Digit i>0 is dark when it and all higher digits are zero and its dp is off.
  always_comb begin
    zero_run  = 1'b1;
    supp_mask = {NUM_DIGITS{1'b0}};
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run     = zero_run && (act_d[4*i +: 4] == 4'd0);
      supp_mask[i] = zero_run && !act_dp_d[i];
    end
    if (supp_q[idx_q]) begin
      an_drive = AN_OFF;
    end else begin
      an_drive = ~(NUM_DIGITS'(1) << idx_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      supp_q <= {NUM_DIGITS{1'b0}};
    end else if (act_upd) begin
      supp_q <= supp_mask;
    end
  end
`else
  always_comb begin
    an_drive = ~(NUM_DIGITS'(1) << idx_q);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BLANK;
      idx_q        <= {IDX_W{1'b0}};
      shadow_q     <= {VAL_W{1'b0}};
      shadow_dp_q  <= {NUM_DIGITS{1'b0}};
      act_q        <= {VAL_W{1'b0}};
      act_dp_q     <= {NUM_DIGITS{1'b0}};
      pending_q    <= 1'b0;
      bcd_q        <= 4'd0;
      an_n_q       <= AN_OFF;
      dp_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= frame_end;
      act_q        <= act_d;
      act_dp_q     <= act_dp_d;
      if (load && !frame_end) begin
        shadow_q    <= value;
        shadow_dp_q <= dp_in;
        pending_q   <= 1'b1;
      end else if (frame_end) begin
        pending_q   <= 1'b0;
      end
      // bcd_out moves to the next digit as the slot ends, ahead of its anode.
      case (state_q)
        ST_BLANK: begin
          if (blank_end) begin
            state_q <= ST_DRIVE;
            an_n_q  <= an_drive;
            dp_n_q  <= ~act_dp_q[idx_q];
          end
        end
        ST_DRIVE: begin
          if (slot_end) begin
            state_q <= ST_BLANK;
            idx_q   <= idx_nxt;
            an_n_q  <= AN_OFF;
            dp_n_q  <= 1'b1;
            bcd_q   <= act_d[{idx_nxt, 2'b00} +: 4];
          end
        end
        default: begin
          state_q <= ST_BLANK;
          idx_q   <= {IDX_W{1'b0}};
          an_n_q  <= AN_OFF;
          dp_n_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bcd_out    = bcd_q;
  assign an_n       = an_n_q;
  assign dp_n       = dp_n_q;
  assign frame_done = frame_done_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (4 digits, 20-cycle slots, 4-cycle blank).
module tb_seg_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  bcd_out;
  logic [3:0]  an_n;
  logic        dp_n;
  logic        frame_done;
  logic        pending;

  int checks;
  int errors;

  seg_scan_ctrl #(
    .NUM_DIGITS (4),
    .DIGIT_CYC  (20),
    .BLANK_CYC  (4),
    .CNT_W      (5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .value      (value),
    .dp_in      (dp_in),
    .bcd_out    (bcd_out),
    .an_n       (an_n),
    .dp_n       (dp_n),
    .frame_done (frame_done),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Walks nsamp samples of a frame from its first cycle, checking every output,
  // and optionally pulses load at up to two sample offsets.
  task automatic check_frame(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] supp,
                             input bit fd0, input int nsamp,
                             input int l1_off, input logic [15:0] l1_v, input logic [3:0] l1_dp,
                             input int l2_off, input logic [15:0] l2_v, input logic [3:0] l2_dp);
    logic       pend;
    logic [3:0] exp_an;
    logic [3:0] one;
    logic       dark;
    int         k;
    pend = 1'b0;
    one  = 4'b0001;
    for (int j = 0; j < nsamp; j++) begin
      k      = j / 20;
      dark   = ((j % 20) < 4) || supp[k];
      exp_an = dark ? 4'hF : ~(one << k);
      chk("an_n", {28'd0, an_n}, {28'd0, exp_an});
      chk("bcd_out", {28'd0, bcd_out}, {28'd0, v[4*k +: 4]});
      chk("dp_n", {31'd0, dp_n}, {31'd0, dark ? 1'b1 : ~dp[k]});
      chk("frame_done", {31'd0, frame_done}, {31'd0, (j == 0) && fd0});
      chk("pending", {31'd0, pending}, {31'd0, pend});
      load = 1'b0;
      if (j == l1_off) begin
        load = 1'b1; value = l1_v; dp_in = l1_dp;
        if (j != 79) pend = 1'b1;
      end
      if (j == l2_off) begin
        load = 1'b1; value = l2_v; dp_in = l2_dp;
        if (j != 79) pend = 1'b1;
      end
      @(negedge clk);
    end
    load = 1'b0;
  endtask

  initial begin
    logic [3:0] supp_h;
    logic [3:0] supp_i;
`ifdef LEADING_ZERO_BLANK_EN
    supp_h = 4'b1100;
    supp_i = 4'b1110;
`else
    supp_h = 4'b0000;
    supp_i = 4'b0000;
`endif
    checks = 0;
    errors = 0;
    load   = 1'b0;
    value  = 16'h0000;
    dp_in  = 4'b0000;
    rst_n  = 1'b1;
    #2;
    rst_n  = 1'b0;
    #1;
    chk("rst_an_n", {28'd0, an_n}, 32'h0000_000F);
    chk("rst_bcd_out", {28'd0, bcd_out}, 32'h0000_0000);
    chk("rst_dp_n", {31'd0, dp_n}, 32'h0000_0001);
    chk("rst_frame_done", {31'd0, frame_done}, 32'h0000_0000);
    chk("rst_pending", {31'd0, pending}, 32'h0000_0000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Frame A: zeros, no frame_done on the very first cycle.
    check_frame(16'h0000, 4'b0000, 4'b0000, 1'b0, 80, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    // Frame B: still zeros while 1234 waits in shadow.
    check_frame(16'h0000, 4'b0000, 4'b0000, 1'b1, 80, 30, 16'h1234, 4'b0100, -1, 16'h0, 4'h0);
    // Frame C: 1234 with dp on digit 2; two loads, the second must win.
    check_frame(16'h1234, 4'b0100, 4'b0000, 1'b1, 80, 10, 16'h1111, 4'b0000, 50, 16'h2222, 4'b0000);
    // Frame D: 2222; load lands exactly on the boundary cycle.
    check_frame(16'h2222, 4'b0000, 4'b0000, 1'b1, 80, 79, 16'h5678, 4'b1001, -1, 16'h0, 4'h0);
    // Frame E: 5678 direct, then codes above 9 queued.
    check_frame(16'h5678, 4'b1001, 4'b0000, 1'b1, 80, 40, 16'hF9A0, 4'b0001, -1, 16'h0, 4'h0);
    // Frame F: stop in the DRIVE part of digit 2.
    check_frame(16'hF9A0, 4'b0001, 4'b0000, 1'b1, 50, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    chk("drive_d2_an_n", {28'd0, an_n}, 32'h0000_000B);
    chk("drive_d2_bcd", {28'd0, bcd_out}, 32'h0000_0009);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_an_n", {28'd0, an_n}, 32'h0000_000F);
    chk("async_bcd_out", {28'd0, bcd_out}, 32'h0000_0000);
    chk("async_dp_n", {31'd0, dp_n}, 32'h0000_0001);
    chk("async_pending", {31'd0, pending}, 32'h0000_0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // Frame G: active cleared by reset; queue 0042.
    check_frame(16'h0000, 4'b0000, 4'b0000, 1'b0, 80, 10, 16'h0042, 4'b0000, -1, 16'h0, 4'h0);
    // Frame H: 0042, leading zeros dark when blanking is built in.
    check_frame(16'h0042, 4'b0000, supp_h, 1'b1, 80, 30, 16'h0000, 4'b0000, -1, 16'h0, 4'h0);
    // Frame I: all zeros, only digit 0 lit when blanking is built in.
    check_frame(16'h0000, 4'b0000, supp_i, 1'b1, 80, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
